// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving a shared carry-in-less W-bit adder for ADD/SUB/INC/NEG.
// Optional completed-operation counter enabled by defining ALU_SEQ_OPCOUNT_EN.
module alu_seq_ctrl #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   op_sel,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] adder_A,
    output logic [W-1:0] adder_B,
    input  logic [W-1:0] adder_sum,
    input  logic         adder_over,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] out_Val,
    output logic         over_LED,
    output logic         nR_LED,
    output logic         nA_LED,
    output logic         nB_LED,
    output logic         busy,
    output logic [7:0]   op_count
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       state;
    logic [W-1:0] a_lat;
    logic         b_sign;
    logic [1:0]   op_lat;

    // Adder operands are loaded one edge ahead of the state that samples adder_sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            a_lat     <= '0;
            b_sign    <= 1'b0;
            op_lat    <= OP_ADD;
            adder_A   <= '0;
            adder_B   <= '0;
            out_Val   <= '0;
            over_LED  <= 1'b0;
            nR_LED    <= 1'b0;
            nA_LED    <= 1'b0;
            nB_LED    <= 1'b0;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_lat     <= A;
                        b_sign    <= B[W-1];
                        op_lat    <= op_sel;
                        nA_LED    <= A[W-1];
                        nB_LED    <= ~op_sel[1] & B[W-1];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (op_sel)
                            OP_ADD: begin
                                state   <= S_EXEC;
                                adder_A <= A;
                                adder_B <= B;
                            end
                            OP_SUB: begin
                                state   <= S_PRE;
                                adder_A <= ~B;
                                adder_B <= W'(1);
                            end
                            OP_INC: begin
                                state   <= S_EXEC;
                                adder_A <= A;
                                adder_B <= W'(1);
                            end
                            OP_NEG: begin
                                state   <= S_EXEC;
                                adder_A <= ~A;
                                adder_B <= W'(1);
                            end
                        endcase
                    end
                end
                S_PRE: begin
                    // adder_sum is -B here; feed it straight back as the EXEC operand.
                    state   <= S_EXEC;
                    adder_A <= a_lat;
                    adder_B <= adder_sum;
                end
                S_EXEC: begin
                    state     <= S_DONE;
                    out_Val   <= adder_sum;
                    nR_LED    <= adder_sum[W-1];
                    res_valid <= 1'b1;
                    adder_A   <= '0;
                    adder_B   <= '0;
                    // Judge SUB overflow on the original operands, so B = most-negative is right.
                    if (op_lat == OP_SUB) begin
                        over_LED <= (a_lat[W-1] != b_sign) && (adder_sum[W-1] != a_lat[W-1]);
                    end else begin
                        over_LED <= adder_over;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_OPCOUNT_EN
    // Counts DONE->IDLE handshakes, wrapping at 256.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= 8'd0;
        end else if (state == S_DONE && res_ready) begin
            op_count <= op_count + 8'd1;
        end
    end
`else
    assign op_count = 8'd0;
`endif

endmodule
